// File: rtl/tx_voq_arbiter.sv
// tx_voq_arbiter: per-source descriptor FIFOs (VOQs) feeding a round-robin offer stage for tx_mac_control.
// Define TX_VOQ_ARB_STATS_EN to add saturating grant/drop statistics counters.
module tx_voq_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int VOQ_DEPTH  = 256,
   parameter int DESC_DEPTH = 8,
   localparam int PTR_W = $clog2(VOQ_DEPTH),
   localparam int SRC_W = $clog2(NUM_PORTS)
) (
   input  logic                       switch_clk,
   input  logic                       switch_rst_n,
   input  logic [NUM_PORTS-1:0]       enq_valid_i,
   input  logic [NUM_PORTS*PTR_W-1:0] enq_ptr_i,
   output logic [NUM_PORTS-1:0]       enq_ready_o,
   output logic                       voq_valid_o,
   output logic [PTR_W-1:0]           voq_ptr_o,
   output logic [SRC_W-1:0]           voq_src_o,
   input  logic                       voq_ready_i,
   output logic [NUM_PORTS-1:0]       q_empty_o
`ifdef TX_VOQ_ARB_STATS_EN
   ,
   output logic [NUM_PORTS*16-1:0]    grant_count_o,
   output logic [15:0]                enq_drop_count_o
`endif
);

   localparam int AW    = $clog2(DESC_DEPTH);
   localparam int CNT_W = AW + 1;

   typedef enum logic {
      IDLE  = 1'b0,
      OFFER = 1'b1
   } state_e;

   state_e               state_q;
   logic [SRC_W-1:0]     rr_q;
   logic [SRC_W-1:0]     rr_d;
   logic [PTR_W-1:0]     mem_q [NUM_PORTS][DESC_DEPTH];
   logic [AW-1:0]        rd_q  [NUM_PORTS];
   logic [AW-1:0]        wr_q  [NUM_PORTS];
   logic [CNT_W-1:0]     cnt_q [NUM_PORTS];
   logic [CNT_W-1:0]     cnt_d [NUM_PORTS];
   logic [NUM_PORTS-1:0] push_s;
   logic [NUM_PORTS-1:0] pop_s;
   logic                 found_s;
   logic [SRC_W-1:0]     grant_s;
   logic [SRC_W-1:0]     idx_s;

   // Round-robin search over the registered empty flags; scanning backwards leaves the nearest hit to rr_q.
   always_comb begin
      found_s = 1'b0;
      grant_s = '0;
      idx_s   = '0;
      for (int k = NUM_PORTS - 1; k >= 0; k--) begin
         idx_s   = SRC_W'((int'(rr_q) + k) % NUM_PORTS);
         found_s = found_s | ~q_empty_o[idx_s];
         grant_s = q_empty_o[idx_s] ? grant_s : idx_s;
      end
      rr_d = (grant_s == SRC_W'(NUM_PORTS - 1)) ? '0 : grant_s + SRC_W'(1);
   end

   // Per-FIFO push/pop qualification and next occupancy.
   always_comb begin
      push_s = '0;
      pop_s  = '0;
      cnt_d  = cnt_q;
      for (int i = 0; i < NUM_PORTS; i++) begin
         push_s[i] = enq_valid_i[i] & enq_ready_o[i];
         pop_s[i]  = (state_q == IDLE) && found_s && (grant_s == SRC_W'(i));
         case ({push_s[i], pop_s[i]})
            2'b10:   cnt_d[i] = cnt_q[i] + CNT_W'(1);
            2'b01:   cnt_d[i] = cnt_q[i] - CNT_W'(1);
            default: cnt_d[i] = cnt_q[i];
         endcase
      end
   end

   // FIFO pointers, occupancy and the registered ready/empty flags.
   always_ff @(posedge switch_clk or negedge switch_rst_n) begin
      if (!switch_rst_n) begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            rd_q[i]  <= '0;
            wr_q[i]  <= '0;
            cnt_q[i] <= '0;
         end
         enq_ready_o <= '1;
         q_empty_o   <= '1;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if (push_s[i]) wr_q[i] <= wr_q[i] + AW'(1);
            if (pop_s[i])  rd_q[i] <= rd_q[i] + AW'(1);
            cnt_q[i]       <= cnt_d[i];
            enq_ready_o[i] <= (cnt_d[i] != CNT_W'(DESC_DEPTH));
            q_empty_o[i]   <= (cnt_d[i] == CNT_W'(0));
         end
      end
   end

   // Descriptor storage; contents are meaningless while the pointers say empty, so no reset.
   always_ff @(posedge switch_clk) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (push_s[i]) mem_q[i][wr_q[i]] <= enq_ptr_i[i*PTR_W +: PTR_W];
      end
   end

   // Offer FSM: pop the granted head in IDLE, hold it in OFFER until tx_mac_control accepts.
   always_ff @(posedge switch_clk or negedge switch_rst_n) begin
      if (!switch_rst_n) begin
         state_q     <= IDLE;
         rr_q        <= '0;
         voq_valid_o <= 1'b0;
         voq_ptr_o   <= '0;
         voq_src_o   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (found_s) begin
                  voq_ptr_o   <= mem_q[grant_s][rd_q[grant_s]];
                  voq_src_o   <= grant_s;
                  voq_valid_o <= 1'b1;
                  rr_q        <= rr_d;
                  state_q     <= OFFER;
               end else begin
                  voq_valid_o <= 1'b0;
               end
            end
            OFFER: begin
               if (voq_ready_i) begin
                  voq_valid_o <= 1'b0;
                  state_q     <= IDLE;
               end
            end
            default: begin
               voq_valid_o <= 1'b0;
               state_q     <= IDLE;
            end
         endcase
      end
   end

`ifdef TX_VOQ_ARB_STATS_EN
   logic drop_s;
   assign drop_s = |(enq_valid_i & ~enq_ready_o);

   // Saturating per-source completed-transfer and rejected-enqueue counters.
   always_ff @(posedge switch_clk or negedge switch_rst_n) begin
      if (!switch_rst_n) begin
         grant_count_o    <= '0;
         enq_drop_count_o <= 16'h0000;
      end else begin
         for (int i = 0; i < NUM_PORTS; i++) begin
            if ((state_q == OFFER) && voq_ready_i && (voq_src_o == SRC_W'(i)) &&
                (grant_count_o[i*16 +: 16] != 16'hFFFF))
               grant_count_o[i*16 +: 16] <= grant_count_o[i*16 +: 16] + 16'd1;
         end
         if (drop_s && (enq_drop_count_o != 16'hFFFF))
            enq_drop_count_o <= enq_drop_count_o + 16'd1;
      end
   end
`endif

endmodule
